// File: rtl/make_clock_div_if.sv
// Bus bundle for make_clock_div: per-channel period/gate requests and derived clock outputs.
interface make_clock_div_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned CW  = 8
);
    logic [NCH*CW-1:0] HIGH_IN;
    logic [NCH*CW-1:0] LOW_IN;
    logic [NCH-1:0]    PERIOD_EN;
    logic [NCH-1:0]    COND_IN;
    logic [NCH-1:0]    COND_IN_EN;
    logic [NCH-1:0]    CLK_OUT;
    logic [NCH-1:0]    CLK_GATE_OUT;
    logic [NCH-1:0]    CLK_VAL_OUT;
    logic [NCH-1:0]    COND_OUT;
    logic [NCH-1:0]    PERIOD_PENDING;
    logic [NCH-1:0]    PRE_EDGE;

    modport master (
        output HIGH_IN, LOW_IN, PERIOD_EN, COND_IN, COND_IN_EN,
        input  CLK_OUT, CLK_GATE_OUT, CLK_VAL_OUT, COND_OUT, PERIOD_PENDING, PRE_EDGE
    );

    modport slave (
        input  HIGH_IN, LOW_IN, PERIOD_EN, COND_IN, COND_IN_EN,
        output CLK_OUT, CLK_GATE_OUT, CLK_VAL_OUT, COND_OUT, PERIOD_PENDING, PRE_EDGE
    );
endinterface

// File: rtl/make_clock_div.sv
// Multi-channel programmable clock divider with shadowed periods and glitch-free gating.
// Optional PRE_EDGE decode enabled by defining MAKE_CLOCK_DIV_PRE_EDGE_EN.
module make_clock_div #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned CW       = 8,
    parameter int unsigned initHigh = 1,
    parameter int unsigned initLow  = 1,
    parameter bit          initGate = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    make_clock_div_if.slave  bus
);

    typedef enum logic {StLow, StHigh} phase_e;

    phase_e          phase_q    [NCH];
    phase_e          phase_d    [NCH];
    logic [CW-1:0]   cnt_q      [NCH];
    logic [CW-1:0]   cnt_d      [NCH];
    logic [CW-1:0]   act_high_q [NCH];
    logic [CW-1:0]   act_high_d [NCH];
    logic [CW-1:0]   act_low_q  [NCH];
    logic [CW-1:0]   act_low_d  [NCH];
    logic [CW-1:0]   shd_high_q [NCH];
    logic [CW-1:0]   shd_high_d [NCH];
    logic [CW-1:0]   shd_low_q  [NCH];
    logic [CW-1:0]   shd_low_d  [NCH];
    logic [NCH-1:0]  pending_q, pending_d;
    logic [NCH-1:0]  raw_q, raw_d;
    logic [NCH-1:0]  val_q;
    logic [NCH-1:0]  new_gate_q, new_gate_d;
    logic [NCH-1:0]  cur_gate_q, cur_gate_d;
    logic [NCH-1:0]  pre_edge;

    always_comb begin
        pending_d  = pending_q;
        raw_d      = raw_q;
        new_gate_d = new_gate_q;
        cur_gate_d = cur_gate_q;
        for (int i = 0; i < NCH; i++) begin
            phase_d[i]    = phase_q[i];
            cnt_d[i]      = cnt_q[i];
            act_high_d[i] = act_high_q[i];
            act_low_d[i]  = act_low_q[i];
            shd_high_d[i] = shd_high_q[i];
            shd_low_d[i]  = shd_low_q[i];
            unique case (phase_q[i])
                StLow: begin
                    if (cnt_q[i] == act_low_q[i]) begin
                        phase_d[i] = StHigh;
                        raw_d[i]   = 1'b1;
                        cnt_d[i]   = '0;
                        // Shadow values govern the high phase starting on this edge.
                        if (pending_q[i]) begin
                            act_high_d[i] = shd_high_q[i];
                            act_low_d[i]  = shd_low_q[i];
                            pending_d[i]  = 1'b0;
                        end
                    end else begin
                        cnt_d[i]      = cnt_q[i] + CW'(1);
                        // Raw stays low across this edge, so the gate may change safely.
                        cur_gate_d[i] = new_gate_q[i];
                    end
                end
                StHigh: begin
                    if (cnt_q[i] == act_high_q[i]) begin
                        phase_d[i] = StLow;
                        raw_d[i]   = 1'b0;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            endcase
            // A write on a boundary edge wins over the clear and applies next boundary.
            if (bus.PERIOD_EN[i]) begin
                shd_high_d[i] = bus.HIGH_IN[i*CW +: CW];
                shd_low_d[i]  = bus.LOW_IN[i*CW +: CW];
                pending_d[i]  = 1'b1;
            end
            if (bus.COND_IN_EN[i]) begin
                new_gate_d[i] = bus.COND_IN[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NCH; i++) begin
                phase_q[i]    <= StLow;
                cnt_q[i]      <= '0;
                act_high_q[i] <= CW'(initHigh);
                act_low_q[i]  <= CW'(initLow);
                shd_high_q[i] <= CW'(initHigh);
                shd_low_q[i]  <= CW'(initLow);
            end
            pending_q  <= '0;
            raw_q      <= '0;
            val_q      <= '0;
            new_gate_q <= {NCH{initGate}};
            cur_gate_q <= {NCH{initGate}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                phase_q[i]    <= phase_d[i];
                cnt_q[i]      <= cnt_d[i];
                act_high_q[i] <= act_high_d[i];
                act_low_q[i]  <= act_low_d[i];
                shd_high_q[i] <= shd_high_d[i];
                shd_low_q[i]  <= shd_low_d[i];
            end
            pending_q  <= pending_d;
            raw_q      <= raw_d;
            val_q      <= raw_d;
            new_gate_q <= new_gate_d;
            cur_gate_q <= cur_gate_d;
        end
    end

`ifdef MAKE_CLOCK_DIV_PRE_EDGE_EN
    always_comb begin
        pre_edge = '0;
        for (int i = 0; i < NCH; i++) begin
            pre_edge[i] = (phase_q[i] == StLow) && (cnt_q[i] == act_low_q[i]) && cur_gate_q[i];
        end
    end
`else
    assign pre_edge = '0;
`endif

    assign bus.CLK_OUT        = raw_q & cur_gate_q;
    assign bus.CLK_GATE_OUT   = cur_gate_q;
    assign bus.CLK_VAL_OUT    = val_q;
    assign bus.COND_OUT       = new_gate_q;
    assign bus.PERIOD_PENDING = pending_q;
    assign bus.PRE_EDGE       = pre_edge;

endmodule

// File: tb/tb_make_clock_div.sv
// Directed self-checking bench for make_clock_div (NCH=2, CW=8, initHigh=1, initLow=2).
module tb_make_clock_div;

`ifdef MAKE_CLOCK_DIV_PRE_EDGE_EN
    localparam bit PreEn = 1'b1;
`else
    localparam bit PreEn = 1'b0;
`endif

    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;
    int   k      = 0;
    bit   ch1_chk = 1'b0;

    make_clock_div_if #(.NCH(2), .CW(8)) bus ();

    make_clock_div #(
        .NCH      (2),
        .CW       (8),
        .initHigh (1),
        .initLow  (2),
        .initGate (1'b1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    // Channel 1 is never stimulated, so it keeps the reset period of 5 (rise at edge 3).
    task automatic tick();
        logic exp1;
        logic pre1;
        @(posedge CLK);
        #1;
        k++;
        if (ch1_chk) begin
            exp1 = (k >= 3) && (((k - 3) % 5) < 2);
            pre1 = PreEn && (k >= 2) && (((k - 2) % 5) == 0);
            check("ch1_clk", {31'b0, bus.CLK_OUT[1]}, {31'b0, exp1});
            check("ch1_val", {31'b0, bus.CLK_VAL_OUT[1]}, {31'b0, exp1});
            check("ch1_pre", {31'b0, bus.PRE_EDGE[1]}, {31'b0, pre1});
            check("ch1_gate", {31'b0, bus.CLK_GATE_OUT[1]}, 32'd1);
            check("ch1_pend", {31'b0, bus.PERIOD_PENDING[1]}, 32'd0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_clk"},  {30'b0, bus.CLK_OUT}, 32'd0);
        check({tag, "_val"},  {30'b0, bus.CLK_VAL_OUT}, 32'd0);
        check({tag, "_pend"}, {30'b0, bus.PERIOD_PENDING}, 32'd0);
        check({tag, "_pre"},  {30'b0, bus.PRE_EDGE}, 32'd0);
        check({tag, "_gate"}, {30'b0, bus.CLK_GATE_OUT}, 32'd3);
        check({tag, "_cond"}, {30'b0, bus.COND_OUT}, 32'd3);
    endtask

    // Ten edges after release with initHigh=1/initLow=2: rise on edge 3, high 2, low 3.
    task automatic default_pattern(input string tag);
        logic [0:9] raw_pat;
        logic [0:9] pre_pat;
        raw_pat = 10'b0011000110;
        pre_pat = 10'b0100001000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check({tag, "_clk0"},  {31'b0, bus.CLK_OUT[0]}, {31'b0, raw_pat[i]});
            check({tag, "_val0"},  {31'b0, bus.CLK_VAL_OUT[0]}, {31'b0, raw_pat[i]});
            check({tag, "_pre0"},  {31'b0, bus.PRE_EDGE[0]}, {31'b0, PreEn & pre_pat[i]});
            check({tag, "_pend0"}, {31'b0, bus.PERIOD_PENDING[0]}, 32'd0);
        end
    endtask

    initial begin
        RST            = 1'b1;
        bus.HIGH_IN    = '0;
        bus.LOW_IN     = '0;
        bus.PERIOD_EN  = '0;
        bus.COND_IN    = '0;
        bus.COND_IN_EN = '0;
        #2 RST = 1'b0;
        #10;
        check_reset_vals("rst");

        @(posedge CLK);
        #1;
        RST     = 1'b1;
        k       = 0;
        ch1_chk = 1'b1;
        default_pattern("dflt");

        // Period change mid-HIGH: HIGH=0/LOW=0 written at edge 14.
        tick(); tick(); tick();
        check("k13_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd1);
        bus.HIGH_IN[7:0] = 8'd0;
        bus.LOW_IN[7:0]  = 8'd0;
        bus.PERIOD_EN    = 2'b01;
        tick();
        bus.PERIOD_EN = 2'b00;
        check("k14_pend0", {31'b0, bus.PERIOD_PENDING[0]}, 32'd1);
        check("k14_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd1);
        tick();
        check("k15_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd0);
        check("k15_pend0", {31'b0, bus.PERIOD_PENDING[0]}, 32'd1);
        tick(); tick();
        check("k17_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd0);
        check("k17_pend0", {31'b0, bus.PERIOD_PENDING[0]}, 32'd1);
        tick();
        check("k18_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd1);
        check("k18_pend0", {31'b0, bus.PERIOD_PENDING[0]}, 32'd0);
        tick();
        check("k19_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd0);
        check("k19_pre0", {31'b0, bus.PRE_EDGE[0]}, {31'b0, PreEn});
        tick();
        check("k20_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd1);
        check("k20_pre0", {31'b0, bus.PRE_EDGE[0]}, 32'd0);
        tick();
        check("k21_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd0);

        // Gate off with active_low=0: condition registers but never applies.
        bus.COND_IN    = 2'b00;
        bus.COND_IN_EN = 2'b01;
        tick();
        bus.COND_IN_EN = 2'b00;
        check("k22_cond0", {31'b0, bus.COND_OUT[0]}, 32'd0);
        check("k22_gate0", {31'b0, bus.CLK_GATE_OUT[0]}, 32'd1);
        check("k22_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd1);
        tick();
        check("k23_gate0", {31'b0, bus.CLK_GATE_OUT[0]}, 32'd1);
        check("k23_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd0);
        tick();
        check("k24_gate0", {31'b0, bus.CLK_GATE_OUT[0]}, 32'd1);
        check("k24_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd1);

        // Reprogram LOW=3: applies at edge 26, gate drops on edge 28.
        bus.HIGH_IN[7:0] = 8'd0;
        bus.LOW_IN[7:0]  = 8'd3;
        bus.PERIOD_EN    = 2'b01;
        tick();
        bus.PERIOD_EN = 2'b00;
        check("k25_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd0);
        check("k25_gate0", {31'b0, bus.CLK_GATE_OUT[0]}, 32'd1);
        check("k25_pend0", {31'b0, bus.PERIOD_PENDING[0]}, 32'd1);
        tick();
        check("k26_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd1);
        check("k26_pend0", {31'b0, bus.PERIOD_PENDING[0]}, 32'd0);
        tick();
        check("k27_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd0);
        check("k27_gate0", {31'b0, bus.CLK_GATE_OUT[0]}, 32'd1);
        tick();
        check("k28_gate0", {31'b0, bus.CLK_GATE_OUT[0]}, 32'd0);
        check("k28_val0", {31'b0, bus.CLK_VAL_OUT[0]}, 32'd0);
        tick(); tick();
        check("k30_pre0", {31'b0, bus.PRE_EDGE[0]}, 32'd0);
        check("k30_cond0", {31'b0, bus.COND_OUT[0]}, 32'd0);
        tick();
        check("k31_val0", {31'b0, bus.CLK_VAL_OUT[0]}, 32'd1);
        check("k31_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd0);

        // Gate back on: registered at edge 32 (HIGH, no apply), applied at edge 33.
        bus.COND_IN    = 2'b01;
        bus.COND_IN_EN = 2'b01;
        tick();
        bus.COND_IN_EN = 2'b00;
        check("k32_cond0", {31'b0, bus.COND_OUT[0]}, 32'd1);
        check("k32_gate0", {31'b0, bus.CLK_GATE_OUT[0]}, 32'd0);
        tick();
        check("k33_gate0", {31'b0, bus.CLK_GATE_OUT[0]}, 32'd1);
        tick(); tick();
        check("k35_pre0", {31'b0, bus.PRE_EDGE[0]}, {31'b0, PreEn});
        check("k35_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd0);

        // Write lands on the rise boundary, so it stays pending; then reset mid-HIGH.
        bus.HIGH_IN[7:0] = 8'd5;
        bus.LOW_IN[7:0]  = 8'd5;
        bus.PERIOD_EN    = 2'b01;
        tick();
        bus.PERIOD_EN = 2'b00;
        check("k36_clk0", {31'b0, bus.CLK_OUT[0]}, 32'd1);
        check("k36_pend0", {31'b0, bus.PERIOD_PENDING[0]}, 32'd1);
        ch1_chk = 1'b0;
        #1 RST = 1'b0;
        #1;
        check_reset_vals("arst");
        @(posedge CLK);
        #1;
        check_reset_vals("arst_hold");
        RST     = 1'b1;
        k       = 0;
        ch1_chk = 1'b1;
        default_pattern("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
